// File: rtl/halloween_frame_encoder.sv
// Packs one-hot action requests into 4-slot, 4-bit opcode frames and presents
// each finished frame with a valid/ready handshake. Flush pads a partial frame.
`timescale 1ns/1ps
module halloween_frame_encoder #(
    parameter logic [3:0] PAD_CODE = 4'b0001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] req_onehot,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        flush,
    output logic [15:0] frame_data,
    output logic        frame_valid,
    input  logic        frame_ready,
    output logic [2:0]  slot_count,
    output logic        err_illegal
);

    typedef enum logic [1:0] {IDLE, FILL, HOLD} state_t;

    // Opcode positions that map to a real breadboard action.
    localparam logic [15:0] LEGAL_MASK = 16'h7773;
    localparam logic [15:0] PAD_FRAME  = {4{PAD_CODE}};

    state_t      state;
    logic        accept;
    logic        is_onehot;
    logic        legal;
    logic [3:0]  opcode;
    logic [15:0] data_ins;
    logic [2:0]  cnt_ins;
    logic [15:0] data_pad;

    assign req_ready = (state != HOLD);
    assign accept    = req_valid & req_ready;
    assign is_onehot = (req_onehot != 16'd0) && ((req_onehot & (req_onehot - 16'd1)) == 16'd0);
    assign legal     = is_onehot && ((req_onehot & ~LEGAL_MASK) == 16'd0);

    always_comb begin
        opcode = 4'd0;
        for (int k = 0; k < 16; k++)
            if (req_onehot[k]) opcode = 4'(k);
    end

    // Frame contents after the current request (if any) takes the next slot.
    always_comb begin
        data_ins = frame_data;
        cnt_ins  = slot_count;
        if (accept && legal && state != HOLD) begin
            data_ins[{slot_count[1:0], 2'b00} +: 4] = opcode;
            cnt_ins = slot_count + 3'd1;
        end
    end

    // Flush pads everything above the request just written.
    always_comb begin
        data_pad = data_ins;
        for (int k = 0; k < 4; k++)
            if (3'(k) >= cnt_ins) data_pad[k*4 +: 4] = PAD_CODE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            slot_count  <= 3'd0;
            frame_data  <= PAD_FRAME;
            frame_valid <= 1'b0;
            err_illegal <= 1'b0;
        end else begin
            err_illegal <= accept & ~legal;
            case (state)
                IDLE, FILL: begin
                    if (cnt_ins == 3'd4) begin
                        state       <= HOLD;
                        slot_count  <= 3'd4;
                        frame_data  <= data_ins;
                        frame_valid <= 1'b1;
                    end else if (flush && cnt_ins != 3'd0) begin
                        state       <= HOLD;
                        slot_count  <= 3'd4;
                        frame_data  <= data_pad;
                        frame_valid <= 1'b1;
                    end else begin
                        state       <= (cnt_ins == 3'd0) ? IDLE : FILL;
                        slot_count  <= cnt_ins;
                        frame_data  <= data_ins;
                    end
                end
                HOLD: begin
                    if (frame_ready) begin
                        state       <= IDLE;
                        slot_count  <= 3'd0;
                        frame_data  <= PAD_FRAME;
                        frame_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_halloween_frame_encoder.sv
// Bench for halloween_frame_encoder: directed table, async-reset and HOLD
// sequences, then random traffic against a queue-based frame model.
`timescale 1ns/1ps
module tb_halloween_frame_encoder;

    localparam logic [3:0] PAD = 4'b0001;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] req_onehot;
    logic        req_valid;
    logic        req_ready;
    logic        flush;
    logic [15:0] frame_data;
    logic        frame_valid;
    logic        frame_ready;
    logic [2:0]  slot_count;
    logic        err_illegal;

    halloween_frame_encoder #(.PAD_CODE(PAD)) dut (
        .clk(clk), .rst(rst), .req_onehot(req_onehot), .req_valid(req_valid),
        .req_ready(req_ready), .flush(flush), .frame_data(frame_data),
        .frame_valid(frame_valid), .frame_ready(frame_ready),
        .slot_count(slot_count), .err_illegal(err_illegal)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rv, input logic [15:0] r, input logic fl, input logic fr);
        req_valid = rv; req_onehot = r; flush = fl; frame_ready = fr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic [2:0] cnt, input logic fv,
                              input logic err, input logic rdy);
        check({tag, ".cnt"}, 16'(slot_count), 16'(cnt));
        check({tag, ".fv"},  16'(frame_valid), 16'(fv));
        check({tag, ".err"}, 16'(err_illegal), 16'(err));
        check({tag, ".rdy"}, 16'(req_ready), 16'(rdy));
    endtask

    // ---------------- behavioural model ----------------
    int q[$];
    bit m_hold;
    bit m_err;

    function automatic bit is_legal(input logic [15:0] r);
        if ($countones(r) != 1) return 1'b0;
        for (int k = 0; k < 16; k++)
            if (r[k]) return (k inside {0, 1, 4, 5, 6, 8, 9, 10, 12, 13, 14});
        return 1'b0;
    endfunction

    function automatic int op_of(input logic [15:0] r);
        for (int k = 0; k < 16; k++) if (r[k]) return k;
        return 0;
    endfunction

    function automatic logic [15:0] model_data();
        logic [15:0] d;
        d = {4{PAD}};
        for (int i = 0; i < q.size(); i++) d[i*4 +: 4] = 4'(q[i]);
        return d;
    endfunction

    task automatic model_step(input logic rv, input logic [15:0] r, input logic fl, input logic fr);
        m_err = 1'b0;
        if (m_hold) begin
            if (fr) begin m_hold = 1'b0; q.delete(); end
        end else begin
            if (rv) begin
                if (is_legal(r)) q.push_back(op_of(r));
                else m_err = 1'b1;
            end
            if (q.size() == 4) m_hold = 1'b1;
            else if (fl && q.size() > 0) begin
                while (q.size() < 4) q.push_back(int'(PAD));
                m_hold = 1'b1;
            end
        end
    endtask

    task automatic check_model(input string tag);
        check_outs(tag, m_hold ? 3'd4 : 3'(q.size()), m_hold, m_err, !m_hold);
        if (m_hold || q.size() == 0) check({tag, ".data"}, frame_data, model_data());
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic        rv;
        logic [15:0] req;
        logic        fl;
        logic        fr;
        logic [2:0]  cnt;
        logic        fv;
        logic        err;
        logic        rdy;
        logic        chk_data;
        logic [15:0] data;
    } vec_t;

    vec_t tbl[21];

    function automatic vec_t mk(input logic rv, input logic [15:0] req, input logic fl,
                                input logic fr, input logic [2:0] cnt, input logic fv,
                                input logic err, input logic chk, input logic [15:0] data);
        vec_t v;
        v.rv = rv; v.req = req; v.fl = fl; v.fr = fr; v.cnt = cnt; v.fv = fv;
        v.err = err; v.rdy = !fv; v.chk_data = chk; v.data = data;
        return v;
    endfunction

    int legal_pos[11] = '{0, 1, 4, 5, 6, 8, 9, 10, 12, 13, 14};

    initial begin
        tbl[0]  = mk(1, 16'h4000, 0, 0, 3'd1, 0, 0, 0, 16'h0000);
        tbl[1]  = mk(1, 16'h0010, 0, 0, 3'd2, 0, 0, 0, 16'h0000);
        tbl[2]  = mk(1, 16'h0400, 0, 0, 3'd3, 0, 0, 0, 16'h0000);
        tbl[3]  = mk(1, 16'h2000, 0, 0, 3'd4, 1, 0, 1, 16'hDA4E);
        tbl[4]  = mk(0, 16'h0000, 0, 0, 3'd4, 1, 0, 1, 16'hDA4E);
        tbl[5]  = mk(0, 16'h0000, 0, 0, 3'd4, 1, 0, 1, 16'hDA4E);
        tbl[6]  = mk(0, 16'h0000, 0, 0, 3'd4, 1, 0, 1, 16'hDA4E);
        tbl[7]  = mk(0, 16'h0000, 0, 1, 3'd0, 0, 0, 1, 16'h1111);
        tbl[8]  = mk(1, 16'h0020, 0, 0, 3'd1, 0, 0, 0, 16'h0000);
        tbl[9]  = mk(1, 16'h0100, 1, 0, 3'd4, 1, 0, 1, 16'h1185);
        tbl[10] = mk(0, 16'h0000, 0, 1, 3'd0, 0, 0, 1, 16'h1111);
        tbl[11] = mk(1, 16'h0000, 0, 1, 3'd0, 0, 1, 1, 16'h1111);
        tbl[12] = mk(1, 16'h0030, 0, 0, 3'd0, 0, 1, 1, 16'h1111);
        tbl[13] = mk(1, 16'h0008, 0, 0, 3'd0, 0, 1, 1, 16'h1111);
        tbl[14] = mk(0, 16'h0000, 0, 0, 3'd0, 0, 0, 1, 16'h1111);
        tbl[15] = mk(0, 16'h0000, 1, 0, 3'd0, 0, 0, 1, 16'h1111);
        tbl[16] = mk(1, 16'h0001, 1, 0, 3'd4, 1, 0, 1, 16'h1110);
        tbl[17] = mk(1, 16'h0002, 0, 1, 3'd0, 0, 0, 1, 16'h1111);
        tbl[18] = mk(1, 16'h0040, 0, 0, 3'd1, 0, 0, 0, 16'h0000);
        tbl[19] = mk(1, 16'h8000, 1, 0, 3'd4, 1, 1, 1, 16'h1116);
        tbl[20] = mk(0, 16'h0000, 0, 1, 3'd0, 0, 0, 1, 16'h1111);

        rst = 1'b1;
        drive(0, 16'h0, 0, 0);
        #1;
        check_outs("reset", 3'd0, 0, 0, 1);
        check("reset.data", frame_data, 16'h1111);
        tick();
        rst = 1'b0;

        for (int i = 0; i < 21; i++) begin
            drive(tbl[i].rv, tbl[i].req, tbl[i].fl, tbl[i].fr);
            tick();
            check_outs($sformatf("vec%0d", i), tbl[i].cnt, tbl[i].fv, tbl[i].err, tbl[i].rdy);
            if (tbl[i].chk_data) check($sformatf("vec%0d.data", i), frame_data, tbl[i].data);
        end

        // async reset mid-frame, between clock edges
        drive(1, 16'h1000, 0, 0); tick();
        drive(1, 16'h0200, 0, 0); tick();
        check("arst.pre_cnt", 16'(slot_count), 16'd2);
        drive(0, 16'h0, 0, 0);
        #2 rst = 1'b1;
        #1;
        check_outs("arst", 3'd0, 0, 0, 1);
        check("arst.data", frame_data, 16'h1111);
        #1 rst = 1'b0;
        drive(1, 16'h0040, 0, 0); tick();
        check("arst.first_cnt", 16'(slot_count), 16'd1);
        drive(1, 16'h0001, 0, 0); tick();
        tick();
        tick();
        check_outs("arst.full", 3'd4, 1, 0, 0);
        check("arst.full_data", frame_data, 16'h0006);
        drive(0, 16'h0, 0, 1); tick();

        // requests held valid during HOLD are not taken
        drive(1, 16'h0010, 0, 0);
        for (int i = 0; i < 4; i++) tick();
        drive(1, 16'h0002, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_outs($sformatf("hold%0d", i), 3'd4, 1, 0, 0);
            check($sformatf("hold%0d.data", i), frame_data, 16'h4444);
        end
        frame_ready = 1'b1; tick();
        check_outs("hold.hs", 3'd0, 0, 0, 1);
        frame_ready = 1'b0; tick();
        check_outs("hold.acc", 3'd1, 0, 0, 1);
        drive(1, 16'h0010, 1, 0); tick();
        check("hold.flush_data", frame_data, 16'h1141);
        drive(0, 16'h0, 0, 1); tick();

        // random traffic against the model
        rst = 1'b1;
        drive(0, 16'h0, 0, 0);
        tick();
        rst = 1'b0;
        q.delete(); m_hold = 1'b0; m_err = 1'b0;
        for (int i = 0; i < 600; i++) begin
            logic [15:0] r;
            logic rv, fl, fr;
            case ($urandom_range(0, 3))
                0, 1:    r = 16'h1 << legal_pos[$urandom_range(0, 10)];
                2:       r = 16'h1 << $urandom_range(0, 15);
                default: r = 16'($urandom);
            endcase
            rv = ($urandom_range(0, 3) != 0);
            fl = ($urandom_range(0, 7) == 0);
            fr = ($urandom_range(0, 2) == 0);
            drive(rv, r, fl, fr);
            tick();
            model_step(rv, r, fl, fr);
            check_model($sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
